onbellek: RTL and testbench
===========================

ONBELLEK -- requirements
Module: onbellek

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning index width; depth DEPTH = 2^ADDR_W (256 words).
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port w_en, input, 1 bit: write enable for the word at addr.
REQ-006 The block SHALL have port r_en, input, 1 bit: read enable for the word at addr.
REQ-007 The block SHALL have port addr, input, ADDR_W bits: word index (cache line index) shared by read and write.
REQ-008 The block SHALL have port data_in, input, DATA_W bits: write data.
REQ-009 The block SHALL have port data_o, output, DATA_W bits: read data.

Function
REQ-010 The block SHALL hold a storage array of DEPTH words of DATA_W bits, indexed directly by addr with no tag or valid logic.
REQ-011 The write SHALL be synchronous: on a rising clk edge with rst=1 and w_en=1, mem[addr] <= data_in; all other words are unchanged.
REQ-012 The write SHALL have a latency of 1 cycle: new data is visible on data_o from the cycle after the write edge.
REQ-013 The read SHALL be combinational, with zero latency: while r_en=1, data_o = mem[addr], following addr and array changes in the same cycle.
REQ-014 While r_en=0, data_o SHALL be driven to all zeros.
REQ-015 On simultaneous w_en=1 and r_en=1 at the same addr, data_o SHALL show the old word until the edge and data_in after the edge; there is no write-through bypass.
REQ-016 With w_en=1 and r_en=1 for one address, the write and read both use the single addr; the block has no separate read and write indices.
REQ-017 With w_en=0, the array SHALL never change, whatever the values of r_en, addr and data_in.
REQ-018 An addr value containing X/Z while w_en=1 is illegal; the block has no defined behaviour in that case and no error output.
REQ-019 The array SHALL update only through the reset and write paths; the block keeps no other internal state and has no handshake, because each access completes in one cycle.

Reset
REQ-020 When rst=0 at a rising clk edge, every word of the array SHALL be cleared to 0 in that single cycle.
REQ-021 A write requested with w_en=1 on an edge where rst=0 SHALL be ignored, because reset has priority.
REQ-022 While rst=0, data_o SHALL follow REQ-013/REQ-014; after the first reset edge, a read of any address returns 0.
REQ-023 Reset applied mid-operation SHALL discard all prior contents, with no partial retention.
REQ-024 Before the first reset, array contents are undefined; the block shall not rely on an initial block.

Verification
REQ-025 Scenario reset clear: write 0xDEADBEEF to addr 0x10, then assert rst=0 for 1 edge, then r_en=1, addr=0x10 -> data_o=0x00000000.
REQ-026 Scenario write then read: rst=1, w_en=1, addr=0x05, data_in=0x12345678, one edge, then w_en=0, r_en=1 -> data_o=0x12345678 in the same cycle.
REQ-027 Scenario read gating: with mem[0x05]=0x12345678, set r_en=0 -> data_o=0x00000000; raise r_en=1 -> 0x12345678 with no clock edge needed.
REQ-028 Scenario simultaneous access: mem[0xFF]=0xAAAAAAAA, then w_en=1, r_en=1, addr=0xFF, data_in=0x55555555 -> data_o=0xAAAAAAAA before the edge and 0x55555555 after it.
REQ-029 Scenario boundary addresses: write 0x00000001 to addr 0x00 and 0xFFFFFFFF to addr 0xFF -> each reads back correctly and addr 0x01 still reads 0.
REQ-030 Scenario reset priority: rst=0, w_en=1, addr=0x20, data_in=0xCAFEF00D on one edge -> after rst=1, addr 0x20 reads 0x00000000.

Source files
------------

// File: rtl/onbellek_if.sv
// Access bus for the direct-mapped word store: a single shared index, with separate write and read enables.
// Latency: the interface itself adds none; read data is combinational and writes commit on the next clk edge.
// Backpressure: none. Every access completes in one cycle, so the bus carries no valid/ready pair.
//
// Ports (signals):
//   w_en    - write enable for the word at addr
//   r_en    - read enable for the word at addr
//   addr    - word index, shared by read and write
//   data_in - write data
//   data_o  - read data (zero while r_en is low)
interface onbellek_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              w_en;
    logic              r_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_o;

    modport master (
        output w_en,
        output r_en,
        output addr,
        output data_in,
        input  data_o
    );

    modport slave (
        input  w_en,
        input  r_en,
        input  addr,
        input  data_in,
        output data_o
    );
endinterface

// File: rtl/onbellek.sv
// Direct-indexed word store (no tag or valid bits): 2^ADDR_W words of DATA_W bits.
// Latency: reads are combinational (0 cycles); a write is visible from the cycle after its clk edge.
// Backpressure: none. The store accepts an access on every cycle.
//
// Ports:
//   clk - clock; all state updates happen on its rising edge
//   rst - synchronous, active-low reset; clears the whole array in one edge
//   bus - onbellek_if.slave carrying w_en, r_en, addr, data_in and data_o
module onbellek #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    onbellek_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Reset wins over a write on the same edge. Clearing every word at once
    // rules out block-RAM mapping: the array is built from flops by design.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.w_en) begin
            mem[bus.addr] <= bus.data_in;
        end
    end

    // There is no write-through bypass. A read of the address being written
    // returns the old word until the edge.
    assign bus.data_o = bus.r_en ? mem[bus.addr] : '0;

endmodule

// File: tb/tb_onbellek.sv
// Self-checking bench for onbellek. A reference array holds the expected contents.
// The stimulus process queues the expected data_o for each sample point.
// The monitor process pops that value and compares it with the DUT output.
module tb_onbellek;
    localparam int DW = 32;
    localparam int AW = 8;

    logic clk;
    logic rst;

    onbellek_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    onbellek #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the storage contents as the specification describes them.
    logic [DW-1:0] ref_mem [256];

    // Inputs currently applied; the model commits them at the next rising edge.
    logic          cur_rst;
    logic          cur_w;
    logic [AW-1:0] cur_a;
    logic [DW-1:0] cur_d;

    logic [DW-1:0] exp_q  [$];
    string         name_q [$];
    event          sample_ev;

    int n_chk  = 0;
    int n_fail = 0;

    // Drive one input set and let combinational read settle.
    // Then queue the expected data_o and signal the monitor.
    task automatic apply(input string nm, input logic r, input logic w, input logic re,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst         = r;
        bus.w_en    = w;
        bus.r_en    = re;
        bus.addr    = a;
        bus.data_in = d;
        cur_rst = r;
        cur_w   = w;
        cur_a   = a;
        cur_d   = d;
        #1;
        exp_q.push_back(re ? ref_mem[a] : '0);
        name_q.push_back(nm);
        -> sample_ev;
        #1;
    endtask

    // One rising edge: the model applies reset or write, then steps away from the edge.
    task automatic tick();
        @(posedge clk);
        if (!cur_rst) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        end else if (cur_w) begin
            ref_mem[cur_a] = cur_d;
        end
        #1;
    endtask

    // Monitor: one comparison per sample event.
    initial begin
        logic [DW-1:0] e;
        string         nm;
        forever begin
            @(sample_ev);
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sample_without_expectation: data_o=%h, no expected value queued", bus.data_o);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (bus.data_o !== e) begin
                    n_fail++;
                    $display("FAIL %s: data_o=%h expected %h (addr=%h r_en=%b)",
                             nm, bus.data_o, e, bus.addr, bus.r_en);
                end
            end
        end
    end

    // Watchdog: stop the run if the stimulus never finishes.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        logic          r, w, re;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [AW-1:0] hot [8];

        for (int i = 0; i < 256; i++) ref_mem[i] = 'x;
        rst = 1'b1; bus.w_en = 1'b0; bus.r_en = 1'b0; bus.addr = '0; bus.data_in = '0;
        cur_rst = 1'b1; cur_w = 1'b0; cur_a = '0; cur_d = '0;
        @(posedge clk); #1;

        // Reset clear: write a word, reset for one edge, then read it back.
        apply("pre_reset_write", 1, 1, 0, 8'h10, 32'hDEADBEEF); tick();
        apply("reset_edge",      0, 0, 0, 8'h10, 32'h0);        tick();
        apply("reset_clear_10",  1, 0, 1, 8'h10, 32'h0);
        apply("reset_clear_00",  1, 0, 1, 8'h00, 32'h0);
        apply("reset_clear_ff",  1, 0, 1, 8'hFF, 32'h0);

        // Write then read in the cycle after the edge.
        apply("write_05",        1, 1, 0, 8'h05, 32'h12345678); tick();
        apply("read_05",         1, 0, 1, 8'h05, 32'h0);

        // Read gating changes data_o with no clock edge.
        apply("gate_off_05",     1, 0, 0, 8'h05, 32'h0);
        apply("gate_on_05",      1, 0, 1, 8'h05, 32'h0);
        apply("addr_follow_06",  1, 0, 1, 8'h06, 32'h0);
        apply("addr_follow_05",  1, 0, 1, 8'h05, 32'h0);

        // Simultaneous read and write on one address: old data before the edge, new data after it.
        apply("write_ff_a",      1, 1, 0, 8'hFF, 32'hAAAAAAAA); tick();
        apply("simul_before",    1, 1, 1, 8'hFF, 32'h55555555); tick();
        apply("simul_after",     1, 0, 1, 8'hFF, 32'h0);

        // Boundary addresses.
        apply("write_00",        1, 1, 0, 8'h00, 32'h00000001); tick();
        apply("write_ff",        1, 1, 0, 8'hFF, 32'hFFFFFFFF); tick();
        apply("bound_00",        1, 0, 1, 8'h00, 32'h0);
        apply("bound_ff",        1, 0, 1, 8'hFF, 32'h0);
        apply("bound_01",        1, 0, 1, 8'h01, 32'h0);

        // With w_en low, the array must not change whatever data_in carries.
        apply("no_write_edge",   1, 0, 1, 8'h05, 32'hFFFF0000); tick();
        apply("no_write_check",  1, 0, 1, 8'h05, 32'h0);

        // Reset has priority over a write on the same edge.
        apply("write_20",        1, 1, 0, 8'h20, 32'h11111111); tick();
        apply("rst_prio_edge",   0, 1, 0, 8'h20, 32'hCAFEF00D); tick();
        apply("rst_prio_20",     1, 0, 1, 8'h20, 32'h0);
        apply("rst_prio_05",     1, 0, 1, 8'h05, 32'h0);

        // Random traffic over a small set of hot addresses, so reads often hit written words.
        for (int i = 0; i < 8; i++) hot[i] = AW'($urandom_range(0, 255));
        hot[0] = 8'h00;
        hot[7] = 8'hFF;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 99) != 0);
            w  = $urandom_range(0, 1);
            re = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 3) != 0) ? hot[$urandom_range(0, 7)] : AW'($urandom_range(0, 255));
            d  = $urandom();
            apply("random", r, w, re, a, d);
            tick();
        end

        #2;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expectations: queue holds %0d entries, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
